// File: rtl/prbs7_pkg.sv
// prbs7_pkg: shared definitions for the PRBS7 error monitor.
//   - mon_state_e      : monitor FSM state encoding (IDLE, HUNT, LOCKED)
//   - counter widths   : total error (32), word (40) and lock-loss (8) counters
//   - PRBS7_WORD_BITS  : bits per checked word, also the largest legal err_cnt
//   - clamp_err()      : limits a per-word error count to PRBS7_WORD_BITS
package prbs7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } mon_state_e;

    localparam int TOTAL_ERRS_W    = 32;
    localparam int WORD_CNT_W      = 40;
    localparam int LOSS_CNT_W      = 8;
    localparam int PRBS7_WORD_BITS = 32;
    localparam int ERR_CNT_W       = 6;
    localparam int RUN_CNT_W       = 8;

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = ERR_CNT_W'(PRBS7_WORD_BITS);

    // A word cannot carry more errors than it has bits; larger counts are clamped.
    function automatic logic [ERR_CNT_W-1:0] clamp_err(input logic [ERR_CNT_W-1:0] e);
        if (e > ERR_MAX) begin
            return ERR_MAX;
        end else begin
            return e;
        end
    endfunction

endpackage

// File: rtl/prbs7_err_monitor_sat_counter.sv
// sat_counter: W-bit accumulator that adds 'inc' every cycle and sticks at
// all-ones instead of wrapping. 'clr' zeroes it and wins over the add.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   clr           : synchronous clear (priority over inc)
//   inc  [W-1:0]  : amount to add this cycle (0 = hold)
//   count[W-1:0]  : registered counter value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic [W-1:0] inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_r;
    logic [W:0]   sum_s;
    logic [W-1:0] count_nxt_s;

    // Next value: clear first, else saturating add (carry-out means overflow).
    always_comb begin
        sum_s = {1'b0, count_r} + {1'b0, inc};
        if (clr) begin
            count_nxt_s = {W{1'b0}};
        end else if (sum_s[W]) begin
            count_nxt_s = {W{1'b1}};
        end else begin
            count_nxt_s = sum_s[W-1:0];
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_r <= {W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/prbs7_err_monitor.sv
// prbs7_err_monitor: lock/unlock supervisor and error accumulator for a PRBS7
// checker. err_cnt is registered (err_q) and clamped to 32; the FSM hunts for
// LOCK_WORDS clean words, then accumulates errors/words while LOCKED and drops
// back to HUNT after UNLOCK_WORDS consecutive bad words (err >= BAD_ERRS).
// Optional feature macro: PRBS7_MON_SNAPSHOT_EN adds snap / snap_errs / snap_words.
// Ports:
//   clk, rstn        : word clock, asynchronous active-low reset
//   enable           : run; low sends the FSM to IDLE on the next edge
//   clear            : synchronous zero of total_errs, word_cnt, lock_losses
//   err_cnt[5:0]     : per-word error count from the checker
//   locked           : FSM is in LOCKED
//   total_errs[31:0] : saturating sum of err_q while LOCKED
//   word_cnt[39:0]   : saturating count of words while LOCKED
//   unlock_evt       : one-cycle pulse on LOCKED->HUNT
//   lock_losses[7:0] : saturating count of unlock events
//   snap (opt)       : capture pre-update total_errs/word_cnt into snap_errs/snap_words
module prbs7_err_monitor
    import prbs7_pkg::*;
#(
    parameter int LOCK_WORDS   = 16,
    parameter int BAD_ERRS     = 8,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [ERR_CNT_W-1:0]    err_cnt,
`ifdef PRBS7_MON_SNAPSHOT_EN
    input  logic                    snap,
    output logic [TOTAL_ERRS_W-1:0] snap_errs,
    output logic [WORD_CNT_W-1:0]   snap_words,
`endif
    output logic                    locked,
    output logic [TOTAL_ERRS_W-1:0] total_errs,
    output logic [WORD_CNT_W-1:0]   word_cnt,
    output logic                    unlock_evt,
    output logic [LOSS_CNT_W-1:0]   lock_losses
);

    localparam logic [RUN_CNT_W-1:0] LOCK_LIM   = RUN_CNT_W'(LOCK_WORDS);
    localparam logic [RUN_CNT_W-1:0] UNLOCK_LIM = RUN_CNT_W'(UNLOCK_WORDS);
    localparam logic [ERR_CNT_W-1:0] BAD_LIM    = ERR_CNT_W'(BAD_ERRS);

    logic [ERR_CNT_W-1:0]    err_q_r;
    mon_state_e              state_r;
    logic [RUN_CNT_W-1:0]    hunt_cnt_r;
    logic [RUN_CNT_W-1:0]    bad_cnt_r;
    logic                    locked_r;
    logic                    unlock_evt_r;

    logic [ERR_CNT_W-1:0]    err_c_s;
    logic                    in_locked_s;
    logic                    bad_word_s;
    logic                    hunt_done_s;
    logic                    unlock_now_s;
    logic [TOTAL_ERRS_W-1:0] total_inc_s;
    logic [WORD_CNT_W-1:0]   word_inc_s;
    logic [LOSS_CNT_W-1:0]   loss_inc_s;

    // Input register: every decision below works on the registered count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q_r <= {ERR_CNT_W{1'b0}};
        end else begin
            err_q_r <= err_cnt;
        end
    end

    // Decode the current word and the transition conditions.
    always_comb begin
        err_c_s      = clamp_err(err_q_r);
        in_locked_s  = (state_r == ST_LOCKED);
        bad_word_s   = (err_c_s >= BAD_LIM);
        // The enable check matters: enable=0 sends LOCKED to IDLE, not HUNT, so no unlock event.
        hunt_done_s  = (state_r == ST_HUNT) && (err_c_s == {ERR_CNT_W{1'b0}})
                       && ((hunt_cnt_r + 8'd1) == LOCK_LIM);
        unlock_now_s = enable && in_locked_s && bad_word_s
                       && ((bad_cnt_r + 8'd1) == UNLOCK_LIM);
        if (in_locked_s) begin
            total_inc_s = TOTAL_ERRS_W'(err_c_s);
            word_inc_s  = {{(WORD_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            total_inc_s = {TOTAL_ERRS_W{1'b0}};
            word_inc_s  = {WORD_CNT_W{1'b0}};
        end
        if (unlock_now_s) begin
            loss_inc_s = {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            loss_inc_s = {LOSS_CNT_W{1'b0}};
        end
    end

    // Monitor FSM with its run-length counters and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            hunt_cnt_r   <= {RUN_CNT_W{1'b0}};
            bad_cnt_r    <= {RUN_CNT_W{1'b0}};
            locked_r     <= 1'b0;
            unlock_evt_r <= 1'b0;
        end else begin
            unlock_evt_r <= unlock_now_s;
            if (!enable) begin
                state_r    <= ST_IDLE;
                hunt_cnt_r <= {RUN_CNT_W{1'b0}};
                bad_cnt_r  <= {RUN_CNT_W{1'b0}};
                locked_r   <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        state_r    <= ST_HUNT;
                        hunt_cnt_r <= {RUN_CNT_W{1'b0}};
                        bad_cnt_r  <= {RUN_CNT_W{1'b0}};
                        locked_r   <= 1'b0;
                    end
                    ST_HUNT: begin
                        if (hunt_done_s) begin
                            state_r    <= ST_LOCKED;
                            hunt_cnt_r <= {RUN_CNT_W{1'b0}};
                            locked_r   <= 1'b1;
                        end else if (err_c_s == {ERR_CNT_W{1'b0}}) begin
                            hunt_cnt_r <= hunt_cnt_r + 8'd1;
                        end else begin
                            hunt_cnt_r <= {RUN_CNT_W{1'b0}};
                        end
                    end
                    ST_LOCKED: begin
                        if (unlock_now_s) begin
                            state_r   <= ST_HUNT;
                            bad_cnt_r <= {RUN_CNT_W{1'b0}};
                            locked_r  <= 1'b0;
                        end else if (bad_word_s) begin
                            bad_cnt_r <= bad_cnt_r + 8'd1;
                        end else begin
                            bad_cnt_r <= {RUN_CNT_W{1'b0}};
                        end
                    end
                    default: begin
                        state_r    <= ST_IDLE;
                        hunt_cnt_r <= {RUN_CNT_W{1'b0}};
                        bad_cnt_r  <= {RUN_CNT_W{1'b0}};
                        locked_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(TOTAL_ERRS_W)) u_total_errs (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clear),
        .inc   (total_inc_s),
        .count (total_errs)
    );

    sat_counter #(.W(WORD_CNT_W)) u_word_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clear),
        .inc   (word_inc_s),
        .count (word_cnt)
    );

    sat_counter #(.W(LOSS_CNT_W)) u_lock_losses (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (clear),
        .inc   (loss_inc_s),
        .count (lock_losses)
    );

`ifdef PRBS7_MON_SNAPSHOT_EN
    logic [TOTAL_ERRS_W-1:0] snap_errs_r;
    logic [WORD_CNT_W-1:0]   snap_words_r;

    // Snapshot takes the accumulator values as they stand before this edge's update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_errs_r  <= {TOTAL_ERRS_W{1'b0}};
            snap_words_r <= {WORD_CNT_W{1'b0}};
        end else if (snap) begin
            snap_errs_r  <= total_errs;
            snap_words_r <= word_cnt;
        end else begin
            snap_errs_r  <= snap_errs_r;
            snap_words_r <= snap_words_r;
        end
    end

    assign snap_errs  = snap_errs_r;
    assign snap_words = snap_words_r;
`endif

    assign locked     = locked_r;
    assign unlock_evt = unlock_evt_r;

endmodule

// File: tb/tb_prbs7_err_monitor.sv
// Bench for prbs7_err_monitor: a cycle model pushes the expected outputs for
// every driven word onto a scoreboard queue; they are popped and compared on
// the following falling edge. Directed checks cover lock latency, restart,
// unlock, saturation, clear priority and asynchronous reset.
module tb_prbs7_err_monitor;

    localparam int LOCK_WORDS   = 16;
    localparam int BAD_ERRS     = 8;
    localparam int UNLOCK_WORDS = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic        snap;
    logic [5:0]  err_cnt;
    logic        locked;
    logic [31:0] total_errs;
    logic [39:0] word_cnt;
    logic        unlock_evt;
    logic [7:0]  lock_losses;
    logic [31:0] snap_errs;
    logic [39:0] snap_words;

    prbs7_err_monitor #(
        .LOCK_WORDS   (LOCK_WORDS),
        .BAD_ERRS     (BAD_ERRS),
        .UNLOCK_WORDS (UNLOCK_WORDS)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .enable      (enable),
        .clear       (clear),
        .err_cnt     (err_cnt),
`ifdef PRBS7_MON_SNAPSHOT_EN
        .snap        (snap),
        .snap_errs   (snap_errs),
        .snap_words  (snap_words),
`endif
        .locked      (locked),
        .total_errs  (total_errs),
        .word_cnt    (word_cnt),
        .unlock_evt  (unlock_evt),
        .lock_losses (lock_losses)
    );

`ifndef PRBS7_MON_SNAPSHOT_EN
    assign snap_errs  = 32'd0;
    assign snap_words = 40'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic        lk;
        logic        ue;
        logic [31:0] te;
        logic [39:0] wc;
        logic [7:0]  ll;
        logic [31:0] se;
        logic [39:0] sw;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int unl_seen = 0;

    // Reference model state
    int          m_state;
    int          m_hunt;
    int          m_bad;
    logic [5:0]  m_errq;
    logic [31:0] m_total;
    logic [39:0] m_word;
    logic [7:0]  m_loss;
    logic        m_lock;
    logic        m_unl;
    logic [31:0] m_se;
    logic [39:0] m_sw;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_hunt = 0; m_bad = 0; m_errq = 6'd0;
        m_total = 32'd0; m_word = 40'd0; m_loss = 8'd0;
        m_lock = 1'b0; m_unl = 1'b0; m_se = 32'd0; m_sw = 40'd0;
        sb_q.delete();
    endtask

    // Behaviour of one clock edge given the inputs presented before it.
    task automatic model_edge(input logic en, input logic cl, input logic [5:0] e);
        logic [5:0]  ec;
        logic        inl, bad, unl;
        logic [32:0] tsum;
        logic [40:0] wsum;
        ec   = (m_errq > 6'd32) ? 6'd32 : m_errq;
        inl  = (m_state == 2);
        bad  = (int'(ec) >= BAD_ERRS);
        unl  = en && inl && bad && (m_bad + 1 == UNLOCK_WORDS);
        if (snap) begin
            m_se = m_total;
            m_sw = m_word;
        end
        tsum = {1'b0, m_total} + (inl ? 33'(ec) : 33'd0);
        wsum = {1'b0, m_word} + (inl ? 41'd1 : 41'd0);
        if (cl) begin
            m_total = 32'd0; m_word = 40'd0; m_loss = 8'd0;
        end else begin
            m_total = tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
            m_word  = wsum[40] ? 40'hFF_FFFF_FFFF : wsum[39:0];
            if (unl && m_loss != 8'hFF) m_loss = m_loss + 8'd1;
        end
        if (!en) begin
            m_state = 0; m_hunt = 0; m_bad = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_hunt = 0; m_bad = 0;
        end else if (m_state == 1) begin
            if (ec == 6'd0) begin
                if (m_hunt + 1 == LOCK_WORDS) begin m_state = 2; m_hunt = 0; end
                else m_hunt = m_hunt + 1;
            end else m_hunt = 0;
        end else begin
            if (bad) begin
                if (m_bad + 1 == UNLOCK_WORDS) begin m_state = 1; m_bad = 0; end
                else m_bad = m_bad + 1;
            end else m_bad = 0;
        end
        m_unl  = unl;
        m_lock = (m_state == 2);
        m_errq = e;
    endtask

    task automatic step(input logic en, input logic cl, input logic [5:0] e);
        exp_t x;
        enable  = en;
        clear   = cl;
        err_cnt = e;
        model_edge(en, cl, e);
        x.lk = m_lock; x.ue = m_unl; x.te = m_total; x.wc = m_word; x.ll = m_loss;
        x.se = m_se; x.sw = m_sw;
        sb_q.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sb_q.pop_front();
        if (unlock_evt) unl_seen++;
        check("sb_locked",      64'(locked),      64'(x.lk));
        check("sb_unlock_evt",  64'(unlock_evt),  64'(x.ue));
        check("sb_total_errs",  64'(total_errs),  64'(x.te));
        check("sb_word_cnt",    64'(word_cnt),    64'(x.wc));
        check("sb_lock_losses", 64'(lock_losses), 64'(x.ll));
`ifdef PRBS7_MON_SNAPSHOT_EN
        check("sb_snap_errs",   64'(snap_errs),   64'(x.se));
        check("sb_snap_words",  64'(snap_words),  64'(x.sw));
`endif
    endtask

    // Drives zero-error words until locked; returns the step count (0 = budget expired).
    task automatic run_to_lock(output int first);
        first = 0;
        for (int i = 1; i <= 40 && first == 0; i++) begin
            step(1'b1, 1'b0, 6'd0);
            if (locked) first = i;
        end
    endtask

    initial begin
        int first;
        logic [31:0] t0;
        rstn = 1'b0; enable = 1'b0; clear = 1'b0; snap = 1'b0; err_cnt = 6'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_locked",      64'(locked),      64'd0);
        check("reset_total_errs",  64'(total_errs),  64'd0);
        check("reset_word_cnt",    64'(word_cnt),    64'd0);
        check("reset_lock_losses", 64'(lock_losses), 64'd0);
        check("reset_unlock_evt",  64'(unlock_evt),  64'd0);
        rstn = 1'b1;

        // Lock: first edge leaves IDLE, then 16 clean words through err_q.
        run_to_lock(first);
        check("lock_latency_steps", 64'(first), 64'd17);
        repeat (3) step(1'b1, 1'b0, 6'd0);
        check("word_cnt_after_20", 64'(word_cnt), 64'd3);

        // Unlock: four bad words (8 errors each), one extra edge to drain err_q.
        t0 = total_errs; unl_seen = 0;
        repeat (4) step(1'b1, 1'b0, 6'd8);
        repeat (2) step(1'b1, 1'b0, 6'd0);
        check("unlock_pulses",      64'(unl_seen),          64'd1);
        check("unlock_lock_losses", 64'(lock_losses),       64'd1);
        check("unlock_total_delta", 64'(total_errs - t0),   64'd32);
        check("unlock_dropped",     64'(locked),            64'd0);

        // Relock resumes from kept values; seven errors per word is not bad.
        run_to_lock(first);
        check("relock", 64'(locked), 64'd1);
        t0 = total_errs; unl_seen = 0;
        repeat (10) step(1'b1, 1'b0, 6'd7);
        step(1'b1, 1'b0, 6'd0);
        check("sub_bad_total_delta", 64'(total_errs - t0), 64'd70);
        check("sub_bad_no_unlock",   64'(unl_seen),        64'd0);
        check("sub_bad_still_lock",  64'(locked),          64'd1);

        // Hunt restart: 15 clean, one error, 16 clean -> lock only after the second run.
        step(1'b0, 1'b0, 6'd0);
        check("disable_idle", 64'(locked), 64'd0);
        first = 0;
        for (int i = 1; i <= 60 && first == 0; i++) begin
            step(1'b1, 1'b0, (i == 16) ? 6'd1 : 6'd0);
            if (locked) first = i;
        end
        check("restart_latency_steps", 64'(first), 64'd33);

        // Saturation of total_errs, and clamping of an out-of-range count.
        force dut.u_total_errs.count_r = 32'hFFFF_FFF0;
        #1 release dut.u_total_errs.count_r;
        m_total = 32'hFFFF_FFF0;
        step(1'b1, 1'b0, 6'd32);
        step(1'b1, 1'b0, 6'd32);
        step(1'b1, 1'b0, 6'd0);
        check("sat_total", 64'(total_errs), 64'hFFFF_FFFF);
        step(1'b1, 1'b0, 6'd0);
        check("sat_hold", 64'(total_errs), 64'hFFFF_FFFF);
        force dut.u_total_errs.count_r = 32'hFFFF_FF00;
        #1 release dut.u_total_errs.count_r;
        m_total = 32'hFFFF_FF00;
        step(1'b1, 1'b0, 6'd63);
        step(1'b1, 1'b0, 6'd0);
        check("clamp_63_as_32", 64'(total_errs), 64'hFFFF_FF20);

        // Clear beats the accumulate of the same edge and leaves the FSM alone.
        step(1'b1, 1'b0, 6'd5);
        step(1'b1, 1'b1, 6'd5);
        check("clear_total",  64'(total_errs),  64'd0);
        check("clear_losses", 64'(lock_losses), 64'd0);
        check("clear_locked", 64'(locked),      64'd1);
        step(1'b1, 1'b0, 6'd0);
        check("after_clear_total", 64'(total_errs), 64'd5);

`ifdef PRBS7_MON_SNAPSHOT_EN
        step(1'b1, 1'b0, 6'd3);
        force dut.u_total_errs.count_r = 32'd100;
        #1 release dut.u_total_errs.count_r;
        m_total = 32'd100;
        snap = 1'b1;
        step(1'b1, 1'b0, 6'd0);
        snap = 1'b0;
        check("snap_errs",       64'(snap_errs),  64'd100);
        check("snap_total_next", 64'(total_errs), 64'd103);
`endif

        // Asynchronous reset mid-LOCKED: outputs clear before any clock edge.
        check("pre_reset_locked", 64'(locked), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("async_rst_locked",      64'(locked),      64'd0);
        check("async_rst_total_errs",  64'(total_errs),  64'd0);
        check("async_rst_word_cnt",    64'(word_cnt),    64'd0);
        check("async_rst_lock_losses", 64'(lock_losses), 64'd0);
        check("async_rst_unlock_evt",  64'(unlock_evt),  64'd0);
        model_reset();
        enable = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        run_to_lock(first);
        check("post_reset_lock_steps", 64'(first), 64'd17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
